edge_window_counter: RTL

- Measurement controller that counts rising edges of a single-bit input over a programmable window of clock cycles.
- Handshake: start/busy/done, with abort.
- Performs rising-edge detection (prev-sample & current-sample) internally, sequences the window with an FSM, and reports a saturating count plus an overflow flag.
- Sits between a host/control block and a raw event signal already synchronous to in_clock.

---
 rtl/edge_pkg.sv | 12 +
 rtl/edge_window_counter_if.sv | 26 ++
 rtl/edge_window_counter_rise_strobe.sv | 20 ++
 rtl/edge_window_counter.sv | 105 ++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and default widths for the edge window counter.
package edge_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIN_W = 16;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/edge_window_counter_if.sv
// Host-side control/result bundle plus the raw event input.
interface edge_window_counter_if
    import edge_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             in_start;
    logic             in_abort;
    logic [WIN_W-1:0] in_window;
    logic             in_signal;
    logic             out_busy;
    logic             out_done;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    modport master (
        output in_start, in_abort, in_window, in_signal,
        input  out_busy, out_done, out_count, out_overflow
    );

    modport slave (
        input  in_start, in_abort, in_window, in_signal,
        output out_busy, out_done, out_count, out_overflow
    );
endinterface

// File: rtl/edge_window_counter_rise_strobe.sv
// Rising-edge detector; prime loads the history bit without ever producing a strobe.
module rise_strobe (
    input  logic clk,
    input  logic rst_n,
    input  logic prime,
    input  logic en,
    input  logic sig,
    output logic strobe
);
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            prev_q <= 1'b0;
        else if (prime || en)
            prev_q <= sig;
    end

    assign strobe = en & ~prev_q & sig;
endmodule

// File: rtl/edge_window_counter.sv
// Counts rising edges of bus.in_signal over a programmed window of cycles.
module edge_window_counter
    import edge_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic                 in_clock,
    input logic                 in_reset_n,
    edge_window_counter_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_q, rem_q;
    logic [CNT_W-1:0] cnt_q, count_q;
    logic             ovf_q, overflow_q, busy_q, done_q;
    logic             strobe;

    rise_strobe u_rise (
        .clk    (in_clock),
        .rst_n  (in_reset_n),
        .prime  (state_q == ARM),
        .en     (state_q == COUNT),
        .sig    (bus.in_signal),
        .strobe (strobe)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.in_start) state_d = (bus.in_window != '0) ? ARM : DONE;
            ARM:   state_d = bus.in_abort ? IDLE : COUNT;
            COUNT: begin
                if (bus.in_abort)
                    state_d = IDLE;
                else if (rem_q == WIN_W'(1))
                    state_d = DONE;
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            state_q    <= IDLE;
            win_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // Status outputs are registered from the next state so they line up with it.
            busy_q  <= (state_d == ARM) || (state_d == COUNT);
            done_q  <= (state_d == DONE);
            unique case (state_q)
                IDLE: begin
                    if (bus.in_start) begin
                        win_q      <= bus.in_window;
                        cnt_q      <= '0;
                        ovf_q      <= 1'b0;
                        overflow_q <= 1'b0;
                        if (bus.in_window == '0)
                            count_q <= '0;
                    end
                end
                ARM: begin
                    if (bus.in_abort) begin
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end else begin
                        rem_q <= win_q;
                    end
                end
                COUNT: begin
                    if (bus.in_abort) begin
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end else begin
                        rem_q <= rem_q - 1'b1;
                        if (strobe) begin
                            if (&cnt_q)
                                ovf_q <= 1'b1;
                            else
                                cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    count_q    <= cnt_q;
                    overflow_q <= ovf_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_busy     = busy_q;
    assign bus.out_done     = done_q;
    assign bus.out_count    = count_q;
    assign bus.out_overflow = overflow_q;
endmodule
